// File: rtl/ram_access_ctrl.sv
// rtl/ram_access_ctrl.sv - request-side cs/we/oe controller for single_port_sync_ram
// Optional macro RAM_CTRL_RSP_BACKPRESSURE_EN: RSP waits for rsp_ready before returning to IDLE.
module ram_access_ctrl #(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  wr_done,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  inout  wire  [DATA_WIDTH-1:0] ram_data,
  output logic                  ram_cs,
  output logic                  ram_we,
  output logic                  ram_oe
);

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] WRITE   = 3'd1;
  localparam logic [2:0] RD_ADDR = 3'd2;
  localparam logic [2:0] RD_DATA = 3'd3;
  localparam logic [2:0] RSP     = 3'd4;

  logic [2:0]            state;
  logic [2:0]            state_next;
  logic                  accept;
  logic                  drive_en;
  logic [DATA_WIDTH-1:0] wdata_q;

  assign accept = req_valid && req_ready;

`ifndef RAM_CTRL_RSP_BACKPRESSURE_EN
  logic unused_rsp_ready;
  assign unused_rsp_ready = rsp_ready;
`endif

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept) state_next = req_we ? WRITE : RD_ADDR;
      WRITE:   state_next = IDLE;
      RD_ADDR: state_next = RD_DATA;
      RD_DATA: state_next = RSP;
`ifdef RAM_CTRL_RSP_BACKPRESSURE_EN
      RSP:     if (rsp_ready) state_next = IDLE;
`else
      RSP:     state_next = IDLE;
`endif
      default: state_next = IDLE;
    endcase
  end

  // Outputs are registered from state_next so they line up with state without combinational decode.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      req_ready <= 1'b1;
      wr_done   <= 1'b0;
      rsp_valid <= 1'b0;
      ram_cs    <= 1'b0;
      ram_we    <= 1'b0;
      ram_oe    <= 1'b0;
      drive_en  <= 1'b0;
    end else begin
      state     <= state_next;
      req_ready <= (state_next == IDLE);
      wr_done   <= (state_next == WRITE);
      rsp_valid <= (state_next == RSP);
      ram_cs    <= (state_next == WRITE) || (state_next == RD_ADDR) || (state_next == RD_DATA);
      ram_we    <= (state_next == WRITE);
      ram_oe    <= (state_next == RD_DATA);
      drive_en  <= (state_next == WRITE);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ram_addr <= '0;
      wdata_q  <= '0;
    end else if (accept) begin
      ram_addr <= req_addr;
      wdata_q  <= req_wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_rdata <= '0;
    end else if (state == RD_DATA) begin
      rsp_rdata <= ram_data;
    end
  end

  assign ram_data = drive_en ? wdata_q : {DATA_WIDTH{1'bz}};

endmodule

// File: tb/tb_ram_access_ctrl.sv
// tb/tb_ram_access_ctrl.sv - self-checking bench for ram_access_ctrl with a behavioural sync RAM
module tb_ram_access_ctrl;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [3:0]  req_addr;
  logic [31:0] req_wdata;
  logic        wr_done;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic [3:0]  ram_addr;
  wire  [31:0] ram_data;
  logic        ram_cs;
  logic        ram_we;
  logic        ram_oe;

  int checks = 0;
  int errors = 0;
  logic [31:0] sb[$];

  ram_access_ctrl #(.ADDR_WIDTH(4), .DATA_WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .wr_done(wr_done),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .ram_addr(ram_addr), .ram_data(ram_data),
    .ram_cs(ram_cs), .ram_we(ram_we), .ram_oe(ram_oe)
  );

  // Registered-read RAM: latches mem[addr] on any non-write cs edge, drives bus while oe.
  logic [31:0] mem [16];
  logic [31:0] ram_q;
  always @(posedge clk) begin
    if (ram_cs) begin
      if (ram_we) mem[ram_addr] <= ram_data;
      else        ram_q <= mem[ram_addr];
    end
  end
  assign ram_data = (ram_cs && ram_oe && !ram_we) ? ram_q : 32'hzzzz_zzzz;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  // Bus monitor and response scoreboard.
  always @(negedge clk) begin
    if (rst_n) begin
      if (ram_cs && ram_oe) chk("bus_no_we_with_oe", {31'd0, ram_we}, 32'd0);
      if (ram_cs && ram_oe && !ram_we) chk("bus_ram_value", ram_data, ram_q);
`ifdef RAM_CTRL_RSP_BACKPRESSURE_EN
      if (rsp_valid && rsp_ready) begin
`else
      if (rsp_valid) begin
`endif
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL rsp_unexpected: got rsp_rdata %h want no response at %0t", rsp_rdata, $time);
        end else begin
          logic [31:0] exp;
          exp = sb.pop_front();
          chk("rsp_rdata", rsp_rdata, exp);
        end
      end
    end
  end

  // Called at a negedge in IDLE; returns at the negedge of the following IDLE cycle.
  task automatic issue(input logic we, input logic [3:0] addr, input logic [31:0] wdata,
                       input logic [31:0] exp, input logic hold);
    req_we = we; req_addr = addr; req_wdata = wdata; req_valid = 1'b1;
    chk("ready_idle", {31'd0, req_ready}, 32'd1);
    if (!we) sb.push_back(exp);
    @(posedge clk);
    @(negedge clk);
    req_valid = hold;
    chk("ready_busy1", {31'd0, req_ready}, 32'd0);
    chk("cs_c1", {31'd0, ram_cs}, 32'd1);
    chk("addr_c1", {28'd0, ram_addr}, {28'd0, addr});
    if (we) begin
      chk("wr_done_c1", {31'd0, wr_done}, 32'd1);
      chk("we_c1", {31'd0, ram_we}, 32'd1);
      chk("oe_c1", {31'd0, ram_oe}, 32'd0);
      chk("wdata_bus", ram_data, wdata);
      @(negedge clk);
      chk("wr_done_c2", {31'd0, wr_done}, 32'd0);
      chk("cs_c2", {31'd0, ram_cs}, 32'd0);
    end else begin
      chk("we_rdaddr", {31'd0, ram_we}, 32'd0);
      chk("oe_rdaddr", {31'd0, ram_oe}, 32'd0);
      chk("rsp_valid_c1", {31'd0, rsp_valid}, 32'd0);
      @(negedge clk);
      chk("oe_rddata", {31'd0, ram_oe}, 32'd1);
      chk("cs_rddata", {31'd0, ram_cs}, 32'd1);
      chk("ready_busy2", {31'd0, req_ready}, 32'd0);
      chk("rsp_valid_c2", {31'd0, rsp_valid}, 32'd0);
      @(negedge clk);
      chk("rsp_valid_c3", {31'd0, rsp_valid}, 32'd1);
      chk("rsp_data_c3", rsp_rdata, exp);
      chk("cs_rsp", {31'd0, ram_cs}, 32'd0);
      chk("oe_rsp", {31'd0, ram_oe}, 32'd0);
      chk("ready_busy3", {31'd0, req_ready}, 32'd0);
      @(negedge clk);
      chk("rsp_valid_c4", {31'd0, rsp_valid}, 32'd0);
      chk("rsp_hold_c4", rsp_rdata, exp);
    end
    chk("ready_back", {31'd0, req_ready}, 32'd1);
  endtask

  typedef struct {
    logic        we;
    logic [3:0]  addr;
    logic [31:0] wdata;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs [10];

  initial begin
    vecs[0] = '{1'b1, 4'd3,  32'hDEAD_BEEF, 32'h0};
    vecs[1] = '{1'b0, 4'd3,  32'h0,         32'hDEAD_BEEF};
    vecs[2] = '{1'b1, 4'd0,  32'h0000_0001, 32'h0};
    vecs[3] = '{1'b1, 4'd15, 32'hFFFF_FFFF, 32'h0};
    vecs[4] = '{1'b0, 4'd0,  32'h0,         32'h0000_0001};
    vecs[5] = '{1'b0, 4'd15, 32'h0,         32'hFFFF_FFFF};
    vecs[6] = '{1'b1, 4'd7,  32'hA5A5_A5A5, 32'h0};
    vecs[7] = '{1'b0, 4'd7,  32'h0,         32'hA5A5_A5A5};
    vecs[8] = '{1'b1, 4'd7,  32'h1234_5678, 32'h0};
    vecs[9] = '{1'b0, 4'd7,  32'h0,         32'h1234_5678};

    rst_n = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0; rsp_ready = 1'b1;
    #1 rst_n = 1'b0;
    #2;
    chk("rst_req_ready", {31'd0, req_ready}, 32'd1);
    chk("rst_wr_done",   {31'd0, wr_done},   32'd0);
    chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("rst_rsp_rdata", rsp_rdata, 32'd0);
    chk("rst_ctrl",      {29'd0, ram_cs, ram_we, ram_oe}, 32'd0);
    chk("rst_ram_addr",  {28'd0, ram_addr}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 10; i++)
      issue(vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].exp, 1'b0);

    // Alternating traffic with req_valid held high throughout.
    issue(1'b1, 4'd5, 32'h0BAD_F00D, 32'h0, 1'b1);
    issue(1'b0, 4'd5, 32'h0,         32'h0BAD_F00D, 1'b1);
    issue(1'b1, 4'd5, 32'hCAFE_BABE, 32'h0, 1'b1);
    issue(1'b0, 4'd5, 32'h0,         32'hCAFE_BABE, 1'b0);

    // Reset landing in RD_DATA aborts the read with no response.
    req_we = 1'b0; req_addr = 4'd3; req_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    chk("abort_in_rddata", {31'd0, ram_oe}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_ready",  {31'd0, req_ready}, 32'd1);
    chk("abort_ctrl",   {29'd0, ram_cs, ram_we, ram_oe}, 32'd0);
    chk("abort_rsp",    {31'd0, rsp_valid}, 32'd0);
    chk("abort_rdata",  rsp_rdata, 32'd0);
    chk("abort_wrdone", {31'd0, wr_done}, 32'd0);
    @(negedge clk);
    chk("abort_rsp_hold", {31'd0, rsp_valid}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("abort_rsp_after", {31'd0, rsp_valid}, 32'd0);
    issue(1'b0, 4'd3, 32'h0, 32'hDEAD_BEEF, 1'b0);

`ifdef RAM_CTRL_RSP_BACKPRESSURE_EN
    rsp_ready = 1'b0;
    req_we = 1'b0; req_addr = 4'd15; req_valid = 1'b1;
    sb.push_back(32'hFFFF_FFFF);
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_rsp_valid", {31'd0, rsp_valid}, 32'd1);
      chk("bp_rsp_rdata", rsp_rdata, 32'hFFFF_FFFF);
      chk("bp_req_ready", {31'd0, req_ready}, 32'd0);
    end
    @(posedge clk);
    #1 rsp_ready = 1'b1;
    @(negedge clk);
    chk("bp_release_valid", {31'd0, rsp_valid}, 32'd1);
    @(negedge clk);
    chk("bp_idle_valid", {31'd0, rsp_valid}, 32'd0);
    chk("bp_idle_ready", {31'd0, req_ready}, 32'd1);
`else
    rsp_ready = 1'b0;
    issue(1'b0, 4'd15, 32'h0, 32'hFFFF_FFFF, 1'b0);
    rsp_ready = 1'b1;
`endif

    @(negedge clk);
    chk("sb_drained", sb.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
